// File: rtl/mtm_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mtm_alu_pkg
// Description : Shared definitions for the ALU serial deserializer: FSM state
//               encoding, opcode constants, error codes, frame geometry and
//               an opcode legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mtm_alu_pkg;

    // Deserializer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TYPE    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_STOP    = 3'd3,
        ST_RESULT  = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    // Opcodes
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // Error codes reported on CTL when err is high
    localparam logic [7:0] ERR_DATA = 8'hC9;
    localparam logic [7:0] ERR_CRC  = 8'hA5;
    localparam logic [7:0] ERR_OP   = 8'h93;

    // Frame geometry
    localparam int FRAME_BITS   = 11;
    localparam int PAYLOAD_BITS = 8;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtm_alu_crc4_serial.sv
`default_nettype none
// ============================================================================
// Module      : mtm_alu_crc4_serial
// Description : Bit-serial CRC-4, polynomial x^4+x+1, initial value 0.
//               One input bit per enabled clock, MSB of the message first.
// Ports       : clk   - clock
//               rst   - asynchronous active-low reset
//               clear - synchronous clear to 0 (wins over en)
//               en    - consume din this cycle
//               din   - message bit
//               crc   - running remainder
// Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_crc4_serial
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [3:0] crc
);

    logic [3:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[3] ^ din;
    assign crc  = r_crc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= 4'd0;
        end else if (clear) begin
            r_crc <= 4'd0;
        end else if (en) begin
            // Shift left, fold feedback into taps x^1 and x^0
            r_crc <= {r_crc[2], r_crc[1], r_crc[0] ^ w_fb, w_fb};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mtm_alu_deserializer_p.sv
`default_nettype none
// ============================================================================
// Module      : mtm_alu_deserializer_p
// Description : Serial frame deserializer for the ALU datapath. Collects
//               2*NPKT DATA frames (B then A, MSB byte first) and one CMD
//               frame, validates packet count, CRC-4 and opcode, and presents
//               either operands/command or an error code with a one-cycle
//               out_valid strobe. Includes an inter-frame idle timeout.
// Config      : MTM_ALU_DESER_CRC_EN - when defined, the CRC-4 is computed
//               and checked; otherwise the CRC field is ignored.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-low reset
//               sin       - serial input, idles high
//               A, B      - operands (DATA_W)
//               CTL       - command byte or error code
//               out_valid - single-cycle result strobe
//               err       - CTL holds an error code
// Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_deserializer_p
    import mtm_alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [7:0]        CTL,
    output logic              out_valid,
    output logic              err
);

    localparam int NPKT  = DATA_W / 8;
    localparam int PKT_W = $clog2(2 * NPKT + 2);
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [PKT_W-1:0] c_PKT_FULL = PKT_W'(2 * NPKT);
    localparam logic [PKT_W-1:0] c_PKT_SAT  = PKT_W'(2 * NPKT + 1);

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_bit_cnt;
    logic                  r_is_cmd;
    logic [7:0]            r_byte;
    logic [2*DATA_W-1:0]   r_data;
    logic [PKT_W-1:0]      r_pkt_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [TO_W-1:0]       w_to_next;
    logic                  w_to_run;
    logic                  w_to_expire;
    logic                  w_clr;
    logic                  w_crc_ok;

    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [7:0]            r_ctl;
    logic                  r_err;
    logic                  r_out_valid;

    assign A         = r_a;
    assign B         = r_b;
    assign CTL       = r_ctl;
    assign err       = r_err;
    assign out_valid = r_out_valid;

    // ------------------------------------------------------------------
    // Timeout: counts IDLE cycles only while a transaction is partial
    // ------------------------------------------------------------------
    assign w_to_run    = (TIMEOUT_CYC != 0) && (r_state == ST_IDLE) && (r_pkt_cnt != '0);
    assign w_to_next   = r_to_cnt + TO_W'(1);
    assign w_to_expire = w_to_run && (w_to_next == TO_W'(TIMEOUT_CYC));

    // Transaction clear: after a result, after a framing error, or on timeout
    assign w_clr = (r_state == ST_RESULT) || (r_state == ST_DRAIN) || w_to_expire;

    // ------------------------------------------------------------------
    // CRC over {B, A, 1'b1, OP}
    // ------------------------------------------------------------------
`ifdef MTM_ALU_DESER_CRC_EN
    logic [3:0] w_crc;
    logic       w_crc_en;
    logic       w_crc_din;

    // DATA payload bits all count; in a CMD frame the leading 0 is replaced
    // by a 1, the three OP bits follow, and the CRC field itself is skipped.
    assign w_crc_en  = (r_state == ST_PAYLOAD) && (!r_is_cmd || (r_bit_cnt < 3'd4));
    assign w_crc_din = (r_is_cmd && (r_bit_cnt == 3'd0)) ? 1'b1 : sin;

    mtm_alu_crc4_serial u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clr),
        .en    (w_crc_en),
        .din   (w_crc_din),
        .crc   (w_crc)
    );

    assign w_crc_ok = (r_byte[3:0] == w_crc);
`else
    assign w_crc_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (!sin) w_next = ST_TYPE;
            ST_TYPE:    w_next = ST_PAYLOAD;
            ST_PAYLOAD: if (r_bit_cnt == 3'd7) w_next = ST_STOP;
            ST_STOP: begin
                if (!sin)          w_next = ST_DRAIN;
                else if (r_is_cmd) w_next = ST_RESULT;
                else               w_next = ST_IDLE;
            end
            // A start bit in the result cycle begins the next frame at once
            ST_RESULT:  w_next = sin ? ST_IDLE : ST_TYPE;
            ST_DRAIN:   if (sin) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= 3'd0;
            r_is_cmd    <= 1'b0;
            r_byte      <= 8'd0;
            r_data      <= '0;
            r_pkt_cnt   <= '0;
            r_to_cnt    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ctl       <= 8'd0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;

            case (r_state)
                ST_TYPE: begin
                    r_is_cmd  <= sin;
                    r_bit_cnt <= 3'd0;
                end
                ST_PAYLOAD: begin
                    r_byte    <= {r_byte[6:0], sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                ST_STOP: begin
                    if (!sin) begin
                        // Framing error
                        r_ctl       <= ERR_DATA;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_pkt_cnt   <= '0;
                    end else if (!r_is_cmd) begin
                        // Surplus frames only bump the saturating count
                        if (r_pkt_cnt < c_PKT_FULL) begin
                            r_data <= {r_data[2*DATA_W-9:0], r_byte};
                        end
                        if (r_pkt_cnt != c_PKT_SAT) begin
                            r_pkt_cnt <= r_pkt_cnt + PKT_W'(1);
                        end
                    end else begin
                        r_out_valid <= 1'b1;
                        if (r_pkt_cnt != c_PKT_FULL) begin
                            r_ctl <= ERR_DATA;
                            r_err <= 1'b1;
                        end else if (!w_crc_ok) begin
                            r_ctl <= ERR_CRC;
                            r_err <= 1'b1;
                        end else if (!is_legal_op(r_byte[6:4])) begin
                            r_ctl <= ERR_OP;
                            r_err <= 1'b1;
                        end else begin
                            r_b   <= r_data[2*DATA_W-1:DATA_W];
                            r_a   <= r_data[DATA_W-1:0];
                            r_ctl <= r_byte;
                            r_err <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            if (w_clr) begin
                r_pkt_cnt <= '0;
            end

            if (w_to_run && !w_to_expire && sin) begin
                r_to_cnt <= w_to_next;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_deserializer_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtm_alu_deserializer_p
// Description : Directed self-checking bench. A 32-bit instance (timeout 16)
//               covers good/error transactions, framing, timeout and
//               mid-frame reset; an 8-bit instance covers back-to-back
//               throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_deserializer_p;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s   = 1'b1;
    logic sel = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   n_ov32 = 0;
    int   n_ov8 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sin32, sin8;
    logic [31:0] a32, b32;
    logic [7:0]  ctl32, a8, b8, ctl8;
    logic        ov32, err32, ov8, err8;

    assign sin32 = sel ? 1'b1 : s;
    assign sin8  = sel ? s : 1'b1;

    mtm_alu_deserializer_p #(.DATA_W(32), .TIMEOUT_CYC(16)) u_dut32 (
        .clk(clk), .rst(rst), .sin(sin32), .A(a32), .B(b32),
        .CTL(ctl32), .out_valid(ov32), .err(err32)
    );

    mtm_alu_deserializer_p #(.DATA_W(8), .TIMEOUT_CYC(16)) u_dut8 (
        .clk(clk), .rst(rst), .sin(sin8), .A(a8), .B(b8),
        .CTL(ctl8), .out_valid(ov8), .err(err8)
    );

    always @(negedge clk) begin
        if (ov32 === 1'b1) n_ov32++;
        if (ov8 === 1'b1) n_ov8++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Remainder of msg(x)*x^4 modulo x^4+x+1 by long division
    function automatic logic [3:0] crc_model(input logic [131:0] msg, input int n);
        logic [135:0] r;
        r = {msg, 4'b0000};
        for (int i = n + 3; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [63:0] b, input logic [63:0] a,
                                            input int w, input logic [2:0] op);
        logic [131:0] msg;
        msg = (132'(b) << (w + 4)) | (132'(a) << 4) | 132'({1'b1, op});
        return {1'b0, op, crc_model(msg, 2 * w + 4)};
    endfunction

    // Entered and left at a falling edge; on return the stop bit was just sampled
    task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
        s = 1'b0; @(negedge clk);
        s = typ;  @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            s = pl[i]; @(negedge clk);
        end
        s = stop; @(negedge clk);
    endtask

    task automatic send_txn(input logic [63:0] b, input logic [63:0] a, input int w,
                            input int ndata, input logic [7:0] cmd);
        logic [127:0] d;
        logic [7:0]   pb;
        d = (128'(b) << w) | 128'(a);
        for (int j = 0; j < ndata; j++) begin
            if (j < 2 * (w / 8)) pb = d[2 * w - 1 - 8 * j -: 8];
            else                 pb = 8'h5A;
            send_frame(1'b0, pb, 1'b1);
        end
        send_frame(1'b1, cmd, 1'b1);
    endtask

    task automatic idle(input int n);
        s = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0]  c;
    logic [31:0] ea, eb;
    int          n0, t1, t2;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_A", 64'(a32), 64'h0);
        chk("rst_B", 64'(b32), 64'h0);
        chk("rst_CTL", 64'(ctl32), 64'h0);
        chk("rst_err", 64'(err32), 64'h0);
        chk("rst_valid", 64'(ov32), 64'h0);
        rst = 1'b1;
        idle(2);

        // ---------------- good ADD ----------------
        c = cmd_byte(64'h2, 64'h3, 32, 3'b100);
        send_txn(64'h2, 64'h3, 32, 8, c);
        chk("t1_valid", 64'(ov32), 64'h1);
        chk("t1_A", 64'(a32), 64'h3);
        chk("t1_B", 64'(b32), 64'h2);
        chk("t1_CTL", 64'(ctl32), 64'(c));
        chk("t1_err", 64'(err32), 64'h0);
        @(negedge clk);
        chk("t1_pulse_width", 64'(ov32), 64'h0);
        ea = 32'h3; eb = 32'h2;
        idle(3);

        // ---------------- CRC field flipped ----------------
        c = cmd_byte(64'h11223344, 64'h55667788, 32, 3'b101) ^ 8'h0F;
        send_txn(64'h11223344, 64'h55667788, 32, 8, c);
        chk("crc_valid", 64'(ov32), 64'h1);
`ifdef MTM_ALU_DESER_CRC_EN
        chk("crc_CTL", 64'(ctl32), 64'hA5);
        chk("crc_err", 64'(err32), 64'h1);
`else
        chk("crc_CTL", 64'(ctl32), 64'(c));
        chk("crc_err", 64'(err32), 64'h0);
        ea = 32'h55667788; eb = 32'h11223344;
`endif
        chk("crc_A", 64'(a32), 64'(ea));
        chk("crc_B", 64'(b32), 64'(eb));
        idle(3);

        // ---------------- 7 DATA frames ----------------
        c = cmd_byte(64'hAAAA5555, 64'h12345678, 32, 3'b100);
        send_txn(64'hAAAA5555, 64'h12345678, 32, 7, c);
        chk("short_CTL", 64'(ctl32), 64'hC9);
        chk("short_err", 64'(err32), 64'h1);
        chk("short_A", 64'(a32), 64'(ea));
        idle(3);

        // ---------------- 9 DATA frames ----------------
        send_txn(64'hAAAA5555, 64'h12345678, 32, 9, c);
        chk("long_CTL", 64'(ctl32), 64'hC9);
        chk("long_err", 64'(err32), 64'h1);
        chk("long_B", 64'(b32), 64'(eb));
        idle(3);

        // ---------------- illegal opcode ----------------
        c = cmd_byte(64'h0F0F0F0F, 64'hF0F0F0F0, 32, 3'b010);
        send_txn(64'h0F0F0F0F, 64'hF0F0F0F0, 32, 8, c);
        chk("op_CTL", 64'(ctl32), 64'h93);
        chk("op_err", 64'(err32), 64'h1);
        chk("op_A", 64'(a32), 64'(ea));
        idle(3);

        // ---------------- framing error in frame 3 ----------------
        send_frame(1'b0, 8'h12, 1'b1);
        send_frame(1'b0, 8'h34, 1'b1);
        send_frame(1'b0, 8'h56, 1'b0);
        chk("frm_valid", 64'(ov32), 64'h1);
        chk("frm_CTL", 64'(ctl32), 64'hC9);
        chk("frm_err", 64'(err32), 64'h1);
        idle(3);
        c = cmd_byte(64'hDEADBEEF, 64'h01020304, 32, 3'b101);
        send_txn(64'hDEADBEEF, 64'h01020304, 32, 8, c);
        chk("frm_next_A", 64'(a32), 64'h01020304);
        chk("frm_next_B", 64'(b32), 64'hDEADBEEF);
        chk("frm_next_CTL", 64'(ctl32), 64'(c));
        chk("frm_next_err", 64'(err32), 64'h0);
        idle(3);

        // ---------------- timeout discards partial transaction ----------------
        n0 = n_ov32;
        for (int j = 0; j < 4; j++) send_frame(1'b0, 8'h77, 1'b1);
        idle(20);
        c = cmd_byte(64'hCAFEF00D, 64'h0BADC0DE, 32, 3'b001);
        send_txn(64'hCAFEF00D, 64'h0BADC0DE, 32, 8, c);
        chk("to_A", 64'(a32), 64'h0BADC0DE);
        chk("to_B", 64'(b32), 64'hCAFEF00D);
        chk("to_CTL", 64'(ctl32), 64'(c));
        chk("to_err", 64'(err32), 64'h0);
        idle(2);
        chk("to_pulses", 64'(n_ov32 - n0), 64'h1);

        // ---------------- reset mid-payload ----------------
        n0 = n_ov32;
        send_frame(1'b0, 8'h81, 1'b1);
        send_frame(1'b0, 8'h42, 1'b1);
        s = 1'b0; @(negedge clk);
        s = 1'b0; @(negedge clk);
        s = 1'b1; @(negedge clk);
        s = 1'b0; @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_A", 64'(a32), 64'h0);
        chk("mrst_B", 64'(b32), 64'h0);
        chk("mrst_CTL", 64'(ctl32), 64'h0);
        chk("mrst_err", 64'(err32), 64'h0);
        chk("mrst_valid", 64'(ov32), 64'h0);
        s = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        c = cmd_byte(64'h00FF00FF, 64'hFF00FF00, 32, 3'b000);
        send_txn(64'h00FF00FF, 64'hFF00FF00, 32, 8, c);
        chk("mrst_next_valid", 64'(ov32), 64'h1);
        chk("mrst_next_A", 64'(a32), 64'hFF00FF00);
        chk("mrst_next_B", 64'(b32), 64'h00FF00FF);
        idle(2);
        chk("mrst_pulses", 64'(n_ov32 - n0), 64'h1);

        // ---------------- DATA_W=8 back-to-back ----------------
        sel = 1'b1;
        idle(2);
        c = cmd_byte(64'h5A, 64'hA5, 8, 3'b000);
        send_txn(64'h5A, 64'hA5, 8, 2, c);
        t1 = cyc;
        chk("b2b_1_valid", 64'(ov8), 64'h1);
        chk("b2b_1_A", 64'(a8), 64'hA5);
        chk("b2b_1_B", 64'(b8), 64'h5A);
        chk("b2b_1_CTL", 64'(ctl8), 64'(c));
        c = cmd_byte(64'hFF, 64'h01, 8, 3'b100);
        send_txn(64'hFF, 64'h01, 8, 2, c);
        t2 = cyc;
        chk("b2b_2_valid", 64'(ov8), 64'h1);
        chk("b2b_2_A", 64'(a8), 64'h01);
        chk("b2b_2_B", 64'(b8), 64'hFF);
        chk("b2b_2_CTL", 64'(ctl8), 64'(c));
        chk("b2b_2_err", 64'(err8), 64'h0);
        chk("b2b_spacing", 64'(t2 - t1), 64'd33);
        idle(3);
        chk("b2b_pulses", 64'(n_ov8), 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
